// File: rtl/usbh_data_tx.sv
// USB full-speed host data-packet transmit framer: PID, payload, CRC16 onto the UTMI TX port.
// Also holds the combinational CRC16 byte-update block used by the framer.

module usbh_crc16 (
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);
    // Reflected form of 0x8005 (0xA001), data bits consumed LSB first.
    // NOTE: blocking assignments inside always_comb model the bit-serial chain;
    // crc_o gets a value before the loop so no latch is inferred.
    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (crc_o[0] ^ data_i[i]) crc_o = (crc_o >> 1) ^ 16'hA001;
            else                      crc_o = crc_o >> 1;
        end
    end
endmodule

module usbh_data_tx #(
    parameter int MAX_LEN = 1023,
    parameter int LEN_W   = 10
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [7:0]        pid_i,
    input  logic              zlp_i,
    input  logic [7:0]        data_i,
    input  logic              data_valid_i,
    input  logic              data_last_i,
    output logic              data_ready_o,
    output logic [7:0]        utmi_data_o,
    output logic              utmi_txvalid_o,
    input  logic              utmi_txready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [15:0]       crc_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_DATA, S_CRC_L, S_CRC_H, S_DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       pid_q;
    logic             zlp_q;
    logic [7:0]       out_q;
    logic             out_vld_q;
    logic [15:0]      crc_q;
    logic [15:0]      crc_next;
    logic [15:0]      crc_out_q;
    logic [LEN_W-1:0] cnt_q;
    logic             done_q;
    logic             ovf_q;
    logic             adv;
    logic             accept;

    // The output register may only move when it is empty or the PHY takes its byte.
    assign adv    = !out_vld_q || utmi_txready_i;
    assign accept = (state_q == S_DATA) && adv && data_valid_i;

    usbh_crc16 u_crc16 (
        .crc_i  (crc_q),
        .data_i (data_i),
        .crc_o  (crc_next)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            pid_q     <= 8'h00;
            zlp_q     <= 1'b0;
            out_q     <= 8'h00;
            out_vld_q <= 1'b0;
            crc_q     <= 16'hFFFF;
            crc_out_q <= 16'h0000;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        pid_q   <= pid_i;
                        zlp_q   <= zlp_i;
                        crc_q   <= 16'hFFFF;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= S_PID;
                    end
                end
                S_PID: begin
                    if (adv) begin
                        out_q     <= pid_q;
                        out_vld_q <= 1'b1;
                        state_q   <= zlp_q ? S_CRC_L : S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        out_q     <= data_i;
                        out_vld_q <= 1'b1;
                        crc_q     <= crc_next;
                        cnt_q     <= cnt_q + 1'b1;
                        if (data_last_i) begin
                            state_q <= S_CRC_L;
                        end else if (cnt_q == LEN_W'(MAX_LEN - 1)) begin
                            // Payload hit the limit with no last marker: truncate here.
                            ovf_q   <= 1'b1;
                            state_q <= S_CRC_L;
                        end
                    end else if (adv) begin
                        out_vld_q <= 1'b0;
                    end
                end
                S_CRC_L: begin
                    if (adv) begin
                        out_q     <= ~crc_q[7:0];
                        out_vld_q <= 1'b1;
                        state_q   <= S_CRC_H;
                    end
                end
                S_CRC_H: begin
                    if (adv) begin
                        out_q     <= ~crc_q[15:8];
                        out_vld_q <= 1'b1;
                        crc_out_q <= ~crc_q;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_vld_q && utmi_txready_i) begin
                        out_vld_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_ready_o   = accept;
    assign utmi_data_o    = out_q;
    assign utmi_txvalid_o = out_vld_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;
    assign overflow_o     = ovf_q;
    assign crc_o          = crc_out_q;
endmodule

// File: tb/tb_usbh_data_tx.sv
// Scoreboard bench for usbh_data_tx: a default-length instance and a MAX_LEN=4 instance
// share one stimulus source; a select picks which one is driven and monitored.

module tb_usbh_data_tx;
    localparam int SMALL_MAX = 4;
    localparam int BIG_MAX   = 1023;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i, zlp_i, data_valid_i, data_last_i, utmi_txready_i;
    logic [7:0]  pid_i, data_i;
    logic        sel_small = 1'b0;

    logic        b_start, b_valid, s_start, s_valid;
    logic        b_ready, s_ready, b_txv, s_txv, b_busy, s_busy, b_done, s_done, b_ovf, s_ovf;
    logic [7:0]  b_udata, s_udata;
    logic [15:0] b_crc, s_crc;

    logic        m_ready, m_txv, m_busy, m_done, m_ovf;
    logic [7:0]  m_udata;
    logic [15:0] m_crc;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  payload[$];
    logic [15:0] model_crc;
    logic [15:0] exp_crc_o;
    logic        exp_ovf;

    always #5 clk_i = ~clk_i;

    assign b_start = start_i && !sel_small;
    assign b_valid = data_valid_i && !sel_small;
    assign s_start = start_i && sel_small;
    assign s_valid = data_valid_i && sel_small;

    always_comb begin
        m_ready = sel_small ? s_ready : b_ready;
        m_txv   = sel_small ? s_txv   : b_txv;
        m_busy  = sel_small ? s_busy  : b_busy;
        m_done  = sel_small ? s_done  : b_done;
        m_ovf   = sel_small ? s_ovf   : b_ovf;
        m_udata = sel_small ? s_udata : b_udata;
        m_crc   = sel_small ? s_crc   : b_crc;
    end

    usbh_data_tx u_big (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(b_start), .pid_i(pid_i), .zlp_i(zlp_i),
        .data_i(data_i), .data_valid_i(b_valid), .data_last_i(data_last_i),
        .data_ready_o(b_ready), .utmi_data_o(b_udata), .utmi_txvalid_o(b_txv),
        .utmi_txready_i(utmi_txready_i), .busy_o(b_busy), .done_o(b_done),
        .overflow_o(b_ovf), .crc_o(b_crc)
    );

    usbh_data_tx #(.MAX_LEN(SMALL_MAX), .LEN_W(3)) u_small (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(s_start), .pid_i(pid_i), .zlp_i(zlp_i),
        .data_i(data_i), .data_valid_i(s_valid), .data_last_i(data_last_i),
        .data_ready_o(s_ready), .utmi_data_o(s_udata), .utmi_txvalid_o(s_txv),
        .utmi_txready_i(utmi_txready_i), .busy_o(s_busy), .done_o(s_done),
        .overflow_o(s_ovf), .crc_o(s_crc)
    );

    // USB CRC16 reference: byte folded into the low bits, then shifted out LSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic load_digits(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'h31 + 8'(i));
    endtask

    // Drives one packet, scoreboards every byte the PHY accepts, then checks the end state.
    task automatic run_packet(input logic [7:0] pid, input logic zlp, input logic has_last,
                              input logic toggle, input logic poke_start, input string name,
                              output int n_acc, output int n_gaps);
        int       cyc = 0;
        int       idx = 0;
        int       done_cnt = 0;
        int       max_len;
        logic     crc_pushed = 1'b0;
        logic     done_next = 1'b0;
        logic     finished = 1'b0;
        logic     seen_valid = 1'b0;
        logic     held = 1'b0;
        logic [7:0] held_byte = 8'h00;
        logic [7:0] e;
        max_len = sel_small ? SMALL_MAX : BIG_MAX;
        n_acc = 0;
        n_gaps = 0;
        exp_q.delete();
        model_crc = 16'hFFFF;
        exp_ovf = 1'b0;

        @(negedge clk_i);
        start_i = 1'b1; pid_i = pid; zlp_i = zlp; data_valid_i = 1'b0; utmi_txready_i = 1'b1;
        exp_q.push_back(pid);
        if (zlp) begin
            exp_q.push_back(~model_crc[7:0]);
            exp_q.push_back(~model_crc[15:8]);
            exp_crc_o  = ~model_crc;
            crc_pushed = 1'b1;
        end
        @(negedge clk_i);
        start_i = 1'b0; zlp_i = 1'b0; pid_i = 8'h00;

        while (!finished && cyc < 300) begin
            utmi_txready_i = toggle ? ((cyc % 2) == 0) : 1'b1;
            data_valid_i   = !zlp && (idx < payload.size());
            data_i         = data_valid_i ? payload[idx] : 8'h00;
            data_last_i    = has_last && (idx == payload.size() - 1);
            start_i        = poke_start && (cyc == 3);
            pid_i          = poke_start ? 8'hFF : 8'h00;
            #1;
            if (held) begin
                n_checks++;
                if (m_txv !== 1'b1 || m_udata !== held_byte) begin
                    n_fail++;
                    $display("FAIL %s hold_stable: got valid=%b byte=%h, need valid=1 byte=%h",
                             name, m_txv, m_udata, held_byte);
                end
            end
            held      = m_txv && !utmi_txready_i;
            held_byte = m_udata;
            if (m_done) done_cnt++;
            if (done_next) begin
                n_checks++;
                if (m_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s done_timing: got done=%b, need 1", name, m_done);
                end
                finished = 1'b1;
            end
            if (m_txv) seen_valid = 1'b1;
            else if (seen_valid && exp_q.size() > 0) n_gaps++;
            if (m_txv && utmi_txready_i && !finished) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_byte: got %h, need none", name, m_udata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_udata !== e) begin
                        n_fail++;
                        $display("FAIL %s phy_byte: got %h, need %h", name, m_udata, e);
                    end
                    if (exp_q.size() == 0 && crc_pushed) done_next = 1'b1;
                end
            end
            if (m_ready) begin
                n_acc++;
                idx++;
                model_crc = crc_step(model_crc, data_i);
                exp_q.push_back(data_i);
                if (data_last_i || n_acc == max_len) begin
                    exp_ovf = !data_last_i;
                    exp_q.push_back(~model_crc[7:0]);
                    exp_q.push_back(~model_crc[15:8]);
                    exp_crc_o  = ~model_crc;
                    crc_pushed = 1'b1;
                end
            end
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0; data_valid_i = 1'b0; data_last_i = 1'b0; utmi_txready_i = 1'b1;

        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL %s timeout: got no done after %0d cycles, need done", name, cyc);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            if (m_done) done_cnt++;
            @(negedge clk_i);
        end
        #1;
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d, need 1", name, done_cnt);
        end
        n_checks++;
        if (m_busy !== 1'b0 || m_txv !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: got busy=%b txvalid=%b, need 0 0", name, m_busy, m_txv);
        end
        n_checks++;
        if (m_crc !== exp_crc_o) begin
            n_fail++;
            $display("FAIL %s crc_o: got %h, need %h", name, m_crc, exp_crc_o);
        end
        n_checks++;
        if (m_ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s overflow: got %b, need %b", name, m_ovf, exp_ovf);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover: got %0d bytes unsent, need 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({b_txv, b_busy, b_done, b_ovf, b_ready, b_udata, b_crc} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_big: got txv=%b busy=%b done=%b ovf=%b rdy=%b data=%h crc=%h, need all 0",
                     b_txv, b_busy, b_done, b_ovf, b_ready, b_udata, b_crc);
        end
        n_checks++;
        if ({s_txv, s_busy, s_done, s_ovf, s_ready, s_udata, s_crc} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_small: got txv=%b busy=%b done=%b ovf=%b rdy=%b data=%h crc=%h, need all 0",
                     s_txv, s_busy, s_done, s_ovf, s_ready, s_udata, s_crc);
        end
    endtask

    task automatic test_zlp();
        int n_acc, n_gaps;
        sel_small = 1'b0;
        payload.delete();
        run_packet(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, "zlp", n_acc, n_gaps);
        n_checks++;
        if (b_crc !== 16'h0000) begin
            n_fail++;
            $display("FAIL zlp crc_const: got %h, need 0000", b_crc);
        end
    endtask

    task automatic test_payload(input string name);
        int n_acc, n_gaps;
        sel_small = 1'b0;
        load_digits(9);
        run_packet(8'h4B, 1'b0, 1'b1, 1'b0, 1'b0, name, n_acc, n_gaps);
        n_checks++;
        if (b_crc !== 16'hB4C8) begin
            n_fail++;
            $display("FAIL %s crc_const: got %h, need b4c8", name, b_crc);
        end
        n_checks++;
        if (n_gaps !== 0 || n_acc !== 9) begin
            n_fail++;
            $display("FAIL %s flow: got gaps=%0d accepted=%0d, need 0 9", name, n_gaps, n_acc);
        end
    endtask

    task automatic test_toggle();
        int n_acc, n_gaps;
        sel_small = 1'b0;
        load_digits(9);
        run_packet(8'h4B, 1'b0, 1'b1, 1'b1, 1'b0, "toggle", n_acc, n_gaps);
        n_checks++;
        if (b_crc !== 16'hB4C8 || n_acc !== 9) begin
            n_fail++;
            $display("FAIL toggle result: got crc=%h accepted=%0d, need b4c8 9", b_crc, n_acc);
        end
    endtask

    task automatic test_overflow();
        int n_acc, n_gaps;
        sel_small = 1'b1;
        load_digits(6);
        run_packet(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, "overflow", n_acc, n_gaps);
        n_checks++;
        if (n_acc !== SMALL_MAX) begin
            n_fail++;
            $display("FAIL overflow accepted: got %0d, need %0d", n_acc, SMALL_MAX);
        end
        repeat (5) @(negedge clk_i);
        #1;
        n_checks++;
        if (s_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow sticky: got %b, need 1", s_ovf);
        end
        // Exactly MAX_LEN bytes ending in last is legal and clears the flag.
        load_digits(SMALL_MAX);
        run_packet(8'h4B, 1'b0, 1'b1, 1'b0, 1'b0, "exact_max", n_acc, n_gaps);
        n_checks++;
        if (n_acc !== SMALL_MAX) begin
            n_fail++;
            $display("FAIL exact_max accepted: got %0d, need %0d", n_acc, SMALL_MAX);
        end
        sel_small = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel_small = 1'b0;
        load_digits(9);
        @(negedge clk_i);
        start_i = 1'b1; pid_i = 8'h4B; zlp_i = 1'b0; utmi_txready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            data_valid_i = 1'b1; data_i = payload[c]; data_last_i = 1'b0;
            @(negedge clk_i);
        end
        rstn_i = 1'b0;
        #1;
        n_checks++;
        if (b_txv !== 1'b0 || b_busy !== 1'b0 || u_big.crc_q !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_mid: got txv=%b busy=%b crc_reg=%h, need 0 0 ffff",
                     b_txv, b_busy, u_big.crc_q);
        end
        data_valid_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        test_payload("after_reset");
    endtask

    task automatic test_back_to_back();
        int n_acc, n_gaps;
        sel_small = 1'b0;
        load_digits(9);
        run_packet(8'h4B, 1'b0, 1'b1, 1'b0, 1'b1, "start_busy", n_acc, n_gaps);
        n_checks++;
        if (b_crc !== 16'hB4C8) begin
            n_fail++;
            $display("FAIL start_busy crc_const: got %h, need b4c8", b_crc);
        end
    endtask

    initial begin
        rstn_i = 1'b0;
        start_i = 1'b0; pid_i = 8'h00; zlp_i = 1'b0;
        data_i = 8'h00; data_valid_i = 1'b0; data_last_i = 1'b0; utmi_txready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        test_reset();
        @(negedge clk_i);
        rstn_i = 1'b1;
        utmi_txready_i = 1'b1;
        test_zlp();
        test_payload("payload");
        test_toggle();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, need completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/usbh_data_tx.md
Name: usbh_data_tx

Overview:
- Transmit-side data-packet framer for the USB full-speed host SIE.
- Takes a PID plus a byte stream from the host transfer logic and drives the UTMI transmit interface with the framed packet: PID, payload, then CRC16 low byte, then CRC16 high byte.
- Instantiates the existing combinational CRC16 byte-update block. Ports on that block: crc_i, data_i, crc_o.
- Sits directly upstream of the UTMI PHY transmit port.

Parameters:
- MAX_LEN, 1023, maximum payload bytes. Longer payloads are truncated and flagged.
- LEN_W, 10, width of the payload byte counter.

Ports:
- clk_i, input, 1, single clock for all logic.
- rstn_i, input, 1, asynchronous active-low reset.
- start_i, input, 1, one-cycle pulse that starts a packet. Sampled only in IDLE.
- pid_i, input, 8, PID byte (DATA0/DATA1/…), latched on start_i.
- zlp_i, input, 1, zero-length packet. Latched on start_i; no payload is requested.
- data_i, input, 8, payload byte.
- data_valid_i, input, 1, payload byte valid.
- data_last_i, input, 1, marks the final payload byte. Qualified by data_valid_i.
- data_ready_o, output, 1, payload byte accepted this cycle.
- utmi_data_o, output, 8, byte to PHY.
- utmi_txvalid_o, output, 1, transmit valid to PHY.
- utmi_txready_i, input, 1, PHY accepts the current byte.
- busy_o, output, 1, high in every state except IDLE.
- done_o, output, 1, one-cycle pulse when the CRC high byte is accepted.
- overflow_o, output, 1, sticky. Set when the payload exceeds MAX_LEN; cleared on start_i.
- crc_o, output, 16, final transmitted CRC value, i.e. {high byte, low byte}. Held until the next start_i.

Behaviour:
- Reset values: all outputs 0, state IDLE, crc register 16'hFFFF, counter 0.
- Output register out_q/out_vld_q drives utmi_data_o/utmi_txvalid_o.
  - The register advances when !out_vld_q || utmi_txready_i ("adv").
  - The byte and txvalid must stay stable until utmi_txready_i.
- States: IDLE, PID, DATA, CRC_L, CRC_H, DONE.
- IDLE:
  - On start_i: latch pid_i and zlp_i, crc register := 16'hFFFF, counter := 0, overflow_o := 0, go to PID.
  - data_valid_i is ignored in IDLE.
- PID:
  - On adv: load pid into out_q with out_vld_q=1.
  - Next state: CRC_L if zlp latched, else DATA.
  - The PID does not enter the CRC.
- DATA:
  - data_ready_o = adv && data_valid_i, combinational.
  - On acceptance: out_q := data_i, crc := crc16(crc, data_i), counter += 1.
  - If data_last_i, go to CRC_L.
  - If counter reaches MAX_LEN without last: go to CRC_L and set overflow_o. Further upstream bytes are not accepted.
- CRC_L: on adv, out_q := ~crc[7:0], go to CRC_H.
- CRC_H: on adv, out_q := ~crc[15:8], crc_o := ~crc, go to DONE.
- DONE:
  - When out_vld_q && utmi_txready_i (CRC high byte accepted): out_vld_q := 0, done_o := 1 for one cycle, go to IDLE.
  - Otherwise hold.
- Throughput: one byte per clock when utmi_txready_i is held high. txvalid stays asserted continuously from the PID to the CRC high byte, provided the source supplies bytes without gaps.
- Source underrun in DATA (data_valid_i low): out_vld_q drops after the current byte is accepted. The upstream engine owns underrun; no error is raised.
- start_i while busy_o=1 is ignored.
- Asynchronous reset mid-packet returns to IDLE immediately with utmi_txvalid_o=0. No CRC bytes are emitted.
- Width rules:
  - The counter is LEN_W bits and saturates at MAX_LEN.
  - The CRC arithmetic is entirely inside the CRC16 block: LSB-first, polynomial 0x8005 reflected, init FFFF, output inverted.

Test Plan:
- ZLP, PID=8'hC3, txready held high → PHY sees C3, 00, 00 on consecutive cycles; crc_o=16'h0000; done_o pulses once, one cycle after the last byte accepted.
- PID=8'h4B, payload "123456789" (31..39), txready high → PHY sees 4B 31 … 39 C8 B4; crc_o=16'hB4C8; no gaps in txvalid.
- Same payload with txready toggled 1/0 every cycle → identical byte sequence; each byte held stable while txready=0; no duplicated or dropped bytes.
- MAX_LEN=4, source sends 6 bytes without last → exactly 4 bytes accepted, then 2 CRC bytes of those 4 bytes; overflow_o=1 until the next start_i.
- rstn_i asserted during the DATA state → txvalid=0, busy_o=0, crc register FFFF. A following "123456789" packet still produces C8 B4.
- start_i pulsed while busy → ignored; the current packet completes unchanged and done_o fires once.
